// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM bus controller: FSM state encoding,
// default bus widths and the minimum legal phase lengths for the 4Kx8 device.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_RESP     = 3'd5,
        ST_TURN     = 3'd6
    } sram_ctrl_state_e;

    localparam int SRAM_ADDR_W = 12;
    localparam int SRAM_DATA_W = 8;

    // Device limits at a 10 ns clock: 10 ns read delay, 10 ns address setup
    // to the rising write strobe, 10 ns bus release after CSB rises.
    localparam int MIN_SETUP_CYC    = 1;
    localparam int MIN_ACCESS_CYC   = 2;
    localparam int MIN_WR_PULSE_CYC = 2;
    localparam int MIN_HOLD_CYC     = 1;
    localparam int MIN_TURN_CYC     = 2;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter used to time every FSM phase; done is high while the
// count sits at zero, i.e. during the last cycle of the loaded phase.
module sram_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/sram_bus_ctrl.sv
// Synchronous master for the asynchronous 4Kx8 SRAM: turns a request stream and a
// read-response stream into registered CSB/WRB/ABUS/DBUS strobe sequences.
module sram_bus_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W       = SRAM_ADDR_W,
    parameter int DATA_W       = SRAM_DATA_W,
    parameter int SETUP_CYC    = 1,
    parameter int ACCESS_CYC   = 2,
    parameter int WR_PULSE_CYC = 2,
    parameter int HOLD_CYC     = 1,
    parameter int TURN_CYC     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              sram_csb,
    output logic              sram_wrb,
    output logic [ADDR_W-1:0] sram_abus,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_oe,
    input  logic [DATA_W-1:0] sram_din
);

    localparam int MAX_PHASE = max_of(max_of(max_of(SETUP_CYC, ACCESS_CYC),
                                             max_of(WR_PULSE_CYC, HOLD_CYC)), TURN_CYC);
    localparam int TIMER_W   = $clog2(MAX_PHASE) + 1;

    if (SETUP_CYC < MIN_SETUP_CYC) begin : g_bad_setup
        $error("sram_bus_ctrl: SETUP_CYC below device minimum");
    end
    if (ACCESS_CYC < MIN_ACCESS_CYC) begin : g_bad_access
        $error("sram_bus_ctrl: ACCESS_CYC below device minimum");
    end
    if (WR_PULSE_CYC < MIN_WR_PULSE_CYC) begin : g_bad_pulse
        $error("sram_bus_ctrl: WR_PULSE_CYC below device minimum");
    end
    if (HOLD_CYC < MIN_HOLD_CYC) begin : g_bad_hold
        $error("sram_bus_ctrl: HOLD_CYC below device minimum");
    end
    if (TURN_CYC < MIN_TURN_CYC) begin : g_bad_turn
        $error("sram_bus_ctrl: TURN_CYC below device minimum");
    end

    sram_ctrl_state_e    state;
    sram_ctrl_state_e    next_state;
    logic                timer_load;
    logic [TIMER_W-1:0]  timer_val;
    logic                timer_done;
    logic                accept;

    logic                we_q;
    logic                ready_q;
    logic                csb_q;
    logic                wrb_q;
    logic                oe_q;
    logic                rsp_valid_q;
    logic [ADDR_W-1:0]   abus_q;
    logic [DATA_W-1:0]   dout_q;
    logic [DATA_W-1:0]   rdata_q;

    sram_phase_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    // ready_q is registered so it stays low throughout reset even though the FSM sits in IDLE.
    assign accept = req_valid && ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Each phase change reloads the timer with that phase's length minus one.
    always_comb begin
        next_state = state;
        timer_load = 1'b0;
        timer_val  = '0;

        case (state)
            ST_IDLE:     if (accept)     next_state = ST_SETUP;
            ST_SETUP:    if (timer_done) next_state = we_q ? ST_WR_PULSE : ST_RD_WAIT;
            ST_RD_WAIT:  if (timer_done) next_state = ST_RESP;
            ST_RESP:     if (rsp_ready)  next_state = ST_TURN;
            ST_WR_PULSE: if (timer_done) next_state = ST_WR_HOLD;
            ST_WR_HOLD:  if (timer_done) next_state = ST_TURN;
            ST_TURN:     if (timer_done) next_state = ST_IDLE;
            default:                     next_state = ST_IDLE;
        endcase

        if (next_state != state) begin
            timer_load = 1'b1;
            case (next_state)
                ST_SETUP:    timer_val = TIMER_W'(SETUP_CYC - 1);
                ST_RD_WAIT:  timer_val = TIMER_W'(ACCESS_CYC - 1);
                ST_WR_PULSE: timer_val = TIMER_W'(WR_PULSE_CYC - 1);
                ST_WR_HOLD:  timer_val = TIMER_W'(HOLD_CYC - 1);
                ST_TURN:     timer_val = TIMER_W'(TURN_CYC - 1);
                default:     timer_val = '0;
            endcase
        end
    end

    // Request fields are latched only at accept, so abus and dout cannot move while csb is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            abus_q <= '0;
            dout_q <= '0;
        end else if (state == ST_IDLE && accept) begin
            we_q   <= req_we;
            abus_q <= req_addr;
            dout_q <= req_wdata;
        end
    end

    // Strobes and handshakes are registered from the next state so they switch with the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q     <= 1'b0;
            csb_q       <= 1'b1;
            wrb_q       <= 1'b1;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            ready_q     <= (next_state == ST_IDLE);
            csb_q       <= !(next_state == ST_RD_WAIT || next_state == ST_WR_PULSE);
            wrb_q       <= (next_state != ST_WR_PULSE);
            oe_q        <= (next_state == ST_WR_PULSE || next_state == ST_WR_HOLD);
            rsp_valid_q <= (next_state == ST_RESP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (state == ST_RD_WAIT && timer_done) begin
            rdata_q <= sram_din;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign sram_csb  = csb_q;
    assign sram_wrb  = wrb_q;
    assign sram_oe   = oe_q;
    assign sram_abus = abus_q;
    assign sram_dout = dout_q;

endmodule
